// File: rtl/mos6502_bus_arbiter.sv
// mos6502_bus_arbiter: shares the external 16-bit address / 8-bit data pin bus
// between the 6502 core and a host access port. Each access occupies a slot of
// WAIT_STATES+1 cycles; the core is stalled through cpu_rdy. Host transfers are
// granted only at CPU slot boundaries, and after each one the CPU gets at least
// CPU_SLOTS completed slots before the host can be granted again.
//
// Ports:
//   wb_clk_i, rst_n             clock, async active-low reset
//   cpu_addr/cpu_dout/cpu_we    core bus request
//   cpu_rdy, cpu_din            core advance enable, read data (= ext_din)
//   host_req/addr/we/wdata      host single-transfer request (level)
//   host_ack, host_rdata        one-cycle completion pulse, last host read data
//   ext_addr/ext_dout/ext_we    pin bus outputs (combinational from owner)
//   ext_din                     pin read data
//   bus_owner                   0 = CPU, 1 = host
module mos6502_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned CPU_SLOTS   = 4
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_din,
  input  logic        host_req,
  input  logic [15:0] host_addr,
  input  logic        host_we,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_dout,
  output logic        ext_we,
  input  logic [7:0]  ext_din,
  output logic        bus_owner
);

  localparam int unsigned WCNT_W   = 3;
  localparam int unsigned CREDIT_W = 4;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 8;

  localparam logic [WCNT_W-1:0]   WCNT_LAST   = WCNT_W'(WAIT_STATES);
  localparam logic [CREDIT_W-1:0] CREDIT_LOAD = CREDIT_W'(CPU_SLOTS);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_CPU  = 2'd1,
    ST_HOST = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
  logic [CREDIT_W-1:0] credit, credit_nxt;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_we;
  logic [DATA_W-1:0]   lat_wdata;
  logic                latch_en;
  logic                host_done;
  logic                slot_last;

  // Read data always flows straight from the pins to the core.
  assign cpu_din   = ext_din;
  assign slot_last = (wcnt == WCNT_LAST);

  // Next-state, slot counting, credit and pin bus steering.
  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    credit_nxt = credit;
    latch_en   = 1'b0;
    host_done  = 1'b0;
    cpu_rdy    = 1'b0;
    bus_owner  = 1'b0;
    ext_addr   = cpu_addr;
    ext_dout   = cpu_dout;
    ext_we     = 1'b0;
    unique case (state)
      ST_RST: begin
        state_nxt = ST_CPU;
        wcnt_nxt  = '0;
      end
      ST_CPU: begin
        ext_we  = cpu_we;
        cpu_rdy = slot_last;
        if (slot_last) begin
          wcnt_nxt = '0;
          if (credit != '0) begin
            credit_nxt = credit - CREDIT_W'(1);
          end
          // Grant decision uses credit before this slot's decrement.
          if (host_req && (credit == '0)) begin
            state_nxt = ST_HOST;
            latch_en  = 1'b1;
          end
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      ST_HOST: begin
        bus_owner = 1'b1;
        ext_addr  = lat_addr;
        ext_dout  = lat_wdata;
        ext_we    = lat_we;
        if (slot_last) begin
          host_done  = 1'b1;
          wcnt_nxt   = '0;
          credit_nxt = CREDIT_LOAD;
          state_nxt  = ST_CPU;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_RST;
      end
    endcase
  end

  // State, counters, latched host request and host result registers.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RST;
      wcnt       <= '0;
      credit     <= '0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      host_rdata <= '0;
      host_ack   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      credit   <= credit_nxt;
      host_ack <= host_done;
      if (latch_en) begin
        lat_addr  <= host_addr;
        lat_we    <= host_we;
        lat_wdata <= host_wdata;
      end
      if (host_done && !lat_we) begin
        host_rdata <= ext_din;
      end
    end
  end

endmodule

// File: tb/tb_mos6502_bus_arbiter.sv
// Bench for mos6502_bus_arbiter: two instances (WAIT_STATES=0 and 2, CPU_SLOTS=4)
// share one stimulus stream. A per-instance behavioural model tracks mode,
// position within the slot, remaining host cycles and credit, and predicts all
// outputs each cycle. Directed phases pin literal values; a random phase follows.
module tb_mos6502_bus_arbiter;

  localparam int unsigned SLOTS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] cpu_addr, host_addr;
  logic [7:0]  cpu_dout, host_wdata;
  logic        cpu_we, host_req, host_we;

  logic        rdy   [2];
  logic [7:0]  cdin  [2];
  logic        ack   [2];
  logic [7:0]  rdata [2];
  logic [15:0] eaddr [2];
  logic [7:0]  edout [2];
  logic        ewe   [2];
  logic [7:0]  din   [2];
  logic        own   [2];

  int n_vec = 0;
  int n_err = 0;

  // Pin-side memory: fixed pattern, 0x50 at 0x0040.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return (a == 16'h0040) ? 8'h50 : (a[7:0] ^ a[15:8] ^ 8'h3C);
  endfunction

  assign din[0] = mem(eaddr[0]);
  assign din[1] = mem(eaddr[1]);

  mos6502_bus_arbiter #(.WAIT_STATES(0), .CPU_SLOTS(SLOTS)) u_ws0 (
    .wb_clk_i(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .cpu_rdy(rdy[0]), .cpu_din(cdin[0]),
    .host_req(host_req), .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_ack(ack[0]), .host_rdata(rdata[0]),
    .ext_addr(eaddr[0]), .ext_dout(edout[0]), .ext_we(ewe[0]), .ext_din(din[0]),
    .bus_owner(own[0])
  );

  mos6502_bus_arbiter #(.WAIT_STATES(2), .CPU_SLOTS(SLOTS)) u_ws2 (
    .wb_clk_i(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .cpu_rdy(rdy[1]), .cpu_din(cdin[1]),
    .host_req(host_req), .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_ack(ack[1]), .host_rdata(rdata[1]),
    .ext_addr(eaddr[1]), .ext_dout(edout[1]), .ext_we(ewe[1]), .ext_din(din[1]),
    .bus_owner(own[1])
  );

  // Model: mode 0 = in reset, 1 = CPU slot, 2 = host transfer.
  int          m_mode [2];
  int          m_pos  [2];
  int          m_left [2];
  int          m_cred [2];
  logic [15:0] m_la   [2];
  logic        m_lwe  [2];
  logic [7:0]  m_lwd  [2];
  logic [7:0]  m_rd   [2];
  logic        m_ack  [2];

  function automatic int ws(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_pos[k] = 0; m_left[k] = 0; m_cred[k] = 0;
      m_la[k] = '0; m_lwe[k] = 1'b0; m_lwd[k] = '0; m_rd[k] = '0; m_ack[k] = 1'b0;
    end
  endtask

  // Advance the model over one rising edge using the inputs held in this cycle.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      logic pulse;
      pulse = 1'b0;
      if (m_mode[k] == 0) begin
        m_mode[k] = 1; m_pos[k] = 0;
      end else if (m_mode[k] == 1) begin
        if (m_pos[k] == ws(k)) begin
          logic grant;
          grant = host_req && (m_cred[k] == 0);
          if (m_cred[k] > 0) m_cred[k] = m_cred[k] - 1;
          m_pos[k] = 0;
          if (grant) begin
            m_mode[k] = 2; m_left[k] = ws(k) + 1;
            m_la[k] = host_addr; m_lwe[k] = host_we; m_lwd[k] = host_wdata;
          end
        end else begin
          m_pos[k] = m_pos[k] + 1;
        end
      end else begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          if (!m_lwe[k]) m_rd[k] = mem(m_la[k]);
          pulse = 1'b1;
          m_cred[k] = SLOTS;
          m_mode[k] = 1; m_pos[k] = 0;
        end
      end
      m_ack[k] = pulse;
    end
  endtask

  // Per-cycle comparison of every output of both instances against the model.
  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [43:0] act, exp;
      logic        e_rdy, e_own, e_we;
      logic [15:0] e_addr;
      logic [7:0]  e_dout;
      e_rdy  = (m_mode[k] == 1) && (m_pos[k] == ws(k));
      e_own  = (m_mode[k] == 2);
      e_we   = (m_mode[k] == 2) ? m_lwe[k] : ((m_mode[k] == 1) ? cpu_we : 1'b0);
      e_addr = (m_mode[k] == 2) ? m_la[k] : cpu_addr;
      e_dout = (m_mode[k] == 2) ? m_lwd[k] : cpu_dout;
      exp = {e_rdy, e_own, e_we, e_addr, e_dout, mem(e_addr), m_ack[k], m_rd[k]};
      act = {rdy[k], own[k], ewe[k], eaddr[k], edout[k], cdin[k], ack[k], rdata[k]};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL model ws%0d t=%0t {rdy,own,we,addr,dout,din,ack,rdata}: got %h want %h",
                 ws(k), $time, act, exp);
      end
    end
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic half();
    @(negedge clk);
    compare_all();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      half();
      edge_();
    end
  endtask

  int  cnt;
  bit  found;
  logic [2:0] ws2_pat [6];

  initial begin
    ws2_pat[0] = 3'd0; ws2_pat[1] = 3'd0; ws2_pat[2] = 3'd1;
    ws2_pat[3] = 3'd0; ws2_pat[4] = 3'd0; ws2_pat[5] = 3'd1;
    rst_n = 1'b0; cpu_addr = 16'hFFFC; cpu_dout = 8'h00; cpu_we = 1'b0;
    host_req = 1'b0; host_addr = 16'h0000; host_we = 1'b0; host_wdata = 8'h00;
    model_reset();
    cyc(2);

    // Reset release: one RST cycle, then CPU.
    rst_n = 1'b1;
    half();
    lit("rst_rdy0", 16'(rdy[0]), 16'h0);
    lit("rst_rdy1", 16'(rdy[1]), 16'h0);
    lit("rst_addr", eaddr[0], 16'hFFFC);
    lit("rst_owner", 16'(own[0]), 16'h0);
    lit("rst_ack", 16'(ack[0]), 16'h0);
    lit("rst_rdata", 16'(rdata[0]), 16'h0000);
    edge_();
    for (int i = 0; i < 6; i++) begin
      half();
      lit("ws0_rdy_run", 16'(rdy[0]), 16'h1);
      lit("ws2_rdy_pat", 16'(rdy[1]), 16'(ws2_pat[i]));
      edge_();
    end

    // CPU write pass-through.
    cpu_we = 1'b1; cpu_addr = 16'h3055; cpu_dout = 8'h1C;
    half();
    lit("cpuw_we", 16'(ewe[0]), 16'h1);
    lit("cpuw_addr", eaddr[0], 16'h3055);
    lit("cpuw_dout", 16'(edout[0]), 16'h001C);
    edge_();
    cpu_we = 1'b0; cpu_addr = 16'h8000;

    // Host read on the zero-wait instance.
    host_req = 1'b1; host_addr = 16'h0040; host_we = 1'b0;
    half();
    lit("hr_owner_pre", 16'(own[0]), 16'h0);
    edge_();
    half();
    lit("hr_owner", 16'(own[0]), 16'h1);
    lit("hr_addr", eaddr[0], 16'h0040);
    lit("hr_rdy", 16'(rdy[0]), 16'h0);
    edge_();
    host_req = 1'b0;
    half();
    lit("hr_ack", 16'(ack[0]), 16'h1);
    lit("hr_rdata", 16'(rdata[0]), 16'h0050);
    lit("hr_rdy_back", 16'(rdy[0]), 16'h1);
    edge_();
    half();
    lit("hr_ack_1cyc", 16'(ack[0]), 16'h0);
    edge_();
    cyc(30);

    // Back-to-back host writes: request held through the ack cycle.
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h1234; host_wdata = 8'h5A;
    cyc(1);
    half();
    lit("hw_owner", 16'(own[0]), 16'h1);
    lit("hw_we", 16'(ewe[0]), 16'h1);
    lit("hw_dout", 16'(edout[0]), 16'h005A);
    edge_();
    host_addr = 16'h1235; host_wdata = 8'h77;
    half();
    lit("hw_ack", 16'(ack[0]), 16'h1);
    edge_();
    cnt = 0; found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      half();
      if (own[0]) begin found = 1'b1; break; end
      if (rdy[0]) cnt++;
      edge_();
    end
    lit("hw2_granted", 16'(found), 16'h1);
    lit("hw2_gap_slots", 16'(cnt), 16'd4);
    lit("hw2_dout", 16'(edout[0]), 16'h0077);
    edge_();
    host_req = 1'b0;
    cyc(40);

    // Wait-state instance: host read occupies three cycles.
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0040;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      half();
      if (own[1]) begin found = 1'b1; break; end
      edge_();
    end
    lit("ws2_granted", 16'(found), 16'h1);
    cnt = 0;
    while (own[1] && cnt < 10) begin
      cnt++;
      edge_();
      half();
    end
    lit("ws2_host_len", 16'(cnt), 16'd3);
    lit("ws2_ack", 16'(ack[1]), 16'h1);
    lit("ws2_rdata", 16'(rdata[1]), 16'h0050);
    edge_();
    host_req = 1'b0;
    cyc(40);

    // Reset during the second HOST cycle of the wait-state instance.
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h2222; host_wdata = 8'h99;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      half();
      if (own[1]) begin found = 1'b1; break; end
      edge_();
    end
    lit("rh_granted", 16'(found), 16'h1);
    edge_();
    rst_n = 1'b0;
    model_reset();
    half();
    lit("rh_owner", 16'(own[1]), 16'h0);
    lit("rh_we", 16'(ewe[1]), 16'h0);
    lit("rh_ack", 16'(ack[1]), 16'h0);
    edge_();
    rst_n = 1'b1;
    cnt = 0; found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      half();
      if (own[1]) begin found = 1'b1; break; end
      cnt++;
      edge_();
    end
    lit("rh_regrant", 16'(found), 16'h1);
    lit("rh_regrant_lat", 16'(cnt), 16'd4);
    edge_();
    host_req = 1'b0;
    cyc(10);

    // Randomised traffic, including occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (!rst_n) model_reset();
      cpu_we     = 1'($urandom_range(0, 1));
      cpu_addr   = 16'($urandom_range(0, 65535));
      cpu_dout   = 8'($urandom_range(0, 255));
      host_req   = ($urandom_range(0, 2) == 0);
      host_we    = 1'($urandom_range(0, 1));
      host_addr  = ($urandom_range(0, 3) == 0) ? 16'h0040 : 16'($urandom_range(0, 65535));
      host_wdata = 8'($urandom_range(0, 255));
      half();
      edge_();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
